// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing arbiter: ALU opcodes and FSM state encoding.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_NOR = 4'd2;
    localparam logic [3:0] ALU_ADD = 4'd3;
    localparam logic [3:0] ALU_MOV = 4'd4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin winner select: combinational one-hot grant from a request vector,
// searching upward from ptr with wrap-around. Reusable for any shared resource.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0]                          req,
    input  logic [((N > 1) ? $clog2(N) : 1)-1:0]  ptr,
    output logic [N-1:0]                          grant,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0]  grant_idx,
    output logic                                  any
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam logic [PW:0] N_EXT = (PW + 1)'(N);

    // first requester found at ptr, ptr+1, ... (mod N) wins
    always_comb begin : search
        logic [PW:0]   sum;
        logic [PW-1:0] idx;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, ptr} + (PW + 1)'(i);
            if (sum >= N_EXT) begin
                sum = sum - N_EXT;
            end
            idx = sum[PW-1:0];
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between NUM_REQ requesters with round-robin grant,
// registered operands and a registered result returned with the requester ID.
// Optional feature macro: ALU_ARB_LOCK_EN (req_lock keeps priority with the winner).
//
//  state | meaning
//  ------+------------------------------------------------------------
//  IDLE  | req_ready = arbiter winner; accept latches op/A/B/id
//  EXEC  | latched operands drive the ALU; result captured at the edge
//  RESP  | rsp_valid high, rsp_* held until rsp_ready
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 32,
    parameter int OP_W    = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*OP_W-1:0]      req_op,
    input  logic [NUM_REQ*DATA_W-1:0]    req_a,
    input  logic [NUM_REQ*DATA_W-1:0]    req_b,
    input  logic [NUM_REQ-1:0]           req_lock,
    output logic [OP_W-1:0]              alu_op,
    output logic [DATA_W-1:0]            alu_a,
    output logic [DATA_W-1:0]            alu_b,
    input  logic [DATA_W-1:0]            alu_result,
    input  logic                         alu_zero,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
    output logic [DATA_W-1:0]            rsp_result,
    output logic                         rsp_zero
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic [1:0]         state;
    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    ptr_next;
    logic [ID_W-1:0]    win_idx;
    logic [ID_W-1:0]    id_q;
    logic [NUM_REQ-1:0] grant;
    logic               win_any;
    logic               accept;
    logic               hold_ptr;
    logic [OP_W-1:0]    op_q;
    logic [OP_W-1:0]    op_mux;
    logic [DATA_W-1:0]  a_q;
    logic [DATA_W-1:0]  b_q;
    logic [DATA_W-1:0]  a_mux;
    logic [DATA_W-1:0]  b_mux;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (win_idx),
        .any       (win_any)
    );

    assign accept    = (state == ST_IDLE) && win_any;
    // Gated by reset so requesters never see an accept while the block is held in reset.
    assign req_ready = ((state == ST_IDLE) && reset) ? grant : '0;
    assign rsp_valid = (state == ST_RESP);
    assign alu_op    = op_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;

`ifdef ALU_ARB_LOCK_EN
    assign hold_ptr = req_lock[win_idx];
`else
    logic lock_unused;
    assign hold_ptr    = 1'b0;
    assign lock_unused = ^req_lock;
`endif

    // operand select from the one-hot grant
    always_comb begin
        op_mux = '0;
        a_mux  = '0;
        b_mux  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                op_mux = req_op[i*OP_W +: OP_W];
                a_mux  = req_a[i*DATA_W +: DATA_W];
                b_mux  = req_b[i*DATA_W +: DATA_W];
            end
        end
    end

    // next round-robin pointer: one past the winner, or the winner itself while locked
    always_comb begin
        if (win_idx == ID_W'(NUM_REQ - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = win_idx + 1'b1;
        end
        if (hold_ptr) begin
            ptr_next = win_idx;
        end
    end

    // control FSM and arbitration pointer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            ptr   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state <= ST_EXEC;
                        ptr   <= ptr_next;
                    end
                end
                ST_EXEC: state <= ST_RESP;
                ST_RESP: begin
                    if (rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // operand latch on accept, result capture at the end of EXEC
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            id_q       <= '0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
        end else begin
            if (accept) begin
                op_q <= op_mux;
                a_q  <= a_mux;
                b_q  <= b_mux;
                id_q <= win_idx;
            end
            if (state == ST_EXEC) begin
                rsp_id     <= id_q;
                rsp_result <= alu_result;
                rsp_zero   <= alu_zero;
            end
        end
    end

endmodule
